// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// -----------------------------------------------------------------------------
// Purpose:
//   PS/2 host-to-device transmitter. Sends one command byte (for example 0xED
//   LED set, 0xFF reset or 0xF4 enable) to the keyboard over the shared PS/2
//   clock/data lines. Runs the full inhibit, request-to-send, 11-bit frame and
//   device-ACK sequence, and drives the lines only by pulling them low.
//
// Ports:
//   i_mclk          system clock (80 MHz)
//   i_reset         synchronous, active-high reset
//   i_tx_data       command byte, captured when the transfer is accepted
//   i_tx_valid      request to send i_tx_data
//   o_tx_ready      high only while idle; accept = i_tx_valid && o_tx_ready
//   i_ps2_clk_in    raw PS/2 clock line level (asynchronous)
//   i_ps2_data_in   raw PS/2 data line level (asynchronous)
//   o_ps2_clk_oe    1 = pull the clock line low
//   o_ps2_data_oe   1 = pull the data line low
//   o_busy          high whenever a transmit is in progress (receive path
//                   should ignore line activity while this is set)
//   o_tx_done       one-cycle pulse, frame acknowledged by the device
//   o_tx_error      one-cycle pulse, timeout or missing ACK
//
// INHIBIT_CYCLES must be at least 2 so the start bit goes low a full cycle
// before the clock line is released.
// -----------------------------------------------------------------------------
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 9600,
  parameter int START_TIMEOUT  = 1200000,
  parameter int BIT_TIMEOUT    = 160000
) (
  input  logic       i_mclk,
  input  logic       i_reset,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  input  logic       i_ps2_clk_in,
  input  logic       i_ps2_data_in,
  output logic       o_ps2_clk_oe,
  output logic       o_ps2_data_oe,
  output logic       o_busy,
  output logic       o_tx_done,
  output logic       o_tx_error
);

  localparam int MAX_A = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
  localparam int MAX_T = (MAX_A > BIT_TIMEOUT) ? MAX_A : BIT_TIMEOUT;
  localparam int TW    = $clog2(MAX_T + 1);

  // Timers are loaded with N-1 and expire on the cycle they read zero, so an
  // N-cycle interval ends exactly N cycles after the load.
  localparam logic [TW-1:0] INH_LOAD   = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] START_LOAD = TW'(START_TIMEOUT - 1);
  localparam logic [TW-1:0] BIT_LOAD   = TW'(BIT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    DATA,
    ACK,
    WAIT_IDLE,
    DONE,
    ERR
  } state_t;

  state_t          r_state, w_nextState;
  logic [TW-1:0]   r_timer, w_timer;
  logic [3:0]      r_bitCnt, w_bitCnt;
  logic [9:0]      r_frame, w_frame;
  logic            r_clkOe, w_clkOe;
  logic            r_dataOe, w_dataOe;
  logic            r_busy, r_ready, r_done, r_error;
  logic            r_clkMeta, r_clkSync, r_clkPrev;
  logic            r_dataMeta, r_dataSync;
  logic            w_fall;
  logic            w_accept;

  // A device falling edge is seen one cycle after the synchronized clock
  // drops, which puts the FSM reaction three mclk cycles after the line edge.
  assign w_fall   = r_clkPrev & ~r_clkSync;
  assign w_accept = i_tx_valid & r_ready;

  // Next-state and next-output logic. Every output is computed here for the
  // state being entered and then registered, so the pins change on the same
  // edge as the state. Falling edges are tested before timer expiry so an edge
  // arriving on the expiry cycle still counts. The timer free-runs down and
  // sticks at zero unless a state reloads it.
  always_comb begin
    w_nextState = r_state;
    w_timer     = (r_timer != '0) ? (r_timer - TW'(1)) : '0;
    w_bitCnt    = r_bitCnt;
    w_frame     = r_frame;
    w_clkOe     = 1'b0;
    w_dataOe    = r_dataOe;

    case (r_state)
      IDLE: begin
        w_dataOe = 1'b0;
        if (w_accept) begin
          w_nextState = INHIBIT;
          w_clkOe     = 1'b1;
          w_timer     = INH_LOAD;
          w_frame     = {1'b1, ~^i_tx_data, i_tx_data};
          w_bitCnt    = 4'd0;
        end
      end

      INHIBIT: begin
        w_clkOe = 1'b1;
        if (r_timer <= TW'(1)) begin
          w_dataOe = 1'b1;
        end
        if (r_timer == '0) begin
          w_nextState = REQ;
          w_clkOe     = 1'b0;
          w_timer     = START_LOAD;
        end
      end

      REQ: begin
        if (w_fall) begin
          w_nextState = DATA;
          w_dataOe    = ~r_frame[0];
          w_frame     = r_frame >> 1;
          w_bitCnt    = 4'd1;
          w_timer     = BIT_LOAD;
        end else if (r_timer == '0) begin
          w_nextState = ERR;
        end
      end

      DATA: begin
        if (w_fall) begin
          w_dataOe = ~r_frame[0];
          w_frame  = r_frame >> 1;
          w_bitCnt = r_bitCnt + 4'd1;
          w_timer  = BIT_LOAD;
          if (r_bitCnt == 4'd9) begin
            w_nextState = ACK;
          end
        end else if (r_timer == '0) begin
          w_nextState = ERR;
        end
      end

      ACK: begin
        if (w_fall) begin
          w_nextState = r_dataSync ? ERR : WAIT_IDLE;
          w_timer     = BIT_LOAD;
        end else if (r_timer == '0) begin
          w_nextState = ERR;
        end
      end

      WAIT_IDLE: begin
        if (r_clkSync && r_dataSync) begin
          w_nextState = DONE;
        end else if (r_timer == '0) begin
          w_nextState = ERR;
        end
      end

      DONE: begin
        w_nextState = IDLE;
        w_dataOe    = 1'b0;
      end

      ERR: begin
        w_nextState = IDLE;
        w_dataOe    = 1'b0;
      end

      default: begin
        w_nextState = IDLE;
        w_dataOe    = 1'b0;
      end
    endcase

    if (w_nextState == ERR) begin
      w_dataOe = 1'b0;
      w_clkOe  = 1'b0;
    end
  end

  // State, timer, frame and output registers plus the two-flop input
  // synchronizers. Reset releases both lines on the next edge and suppresses
  // any done/error pulse; the synchronizers reset to the idle (high) level.
  always_ff @(posedge i_mclk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_timer    <= '0;
      r_bitCnt   <= 4'd0;
      r_frame    <= 10'd0;
      r_clkOe    <= 1'b0;
      r_dataOe   <= 1'b0;
      r_busy     <= 1'b0;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_clkMeta  <= 1'b1;
      r_clkSync  <= 1'b1;
      r_clkPrev  <= 1'b1;
      r_dataMeta <= 1'b1;
      r_dataSync <= 1'b1;
    end else begin
      r_state    <= w_nextState;
      r_timer    <= w_timer;
      r_bitCnt   <= w_bitCnt;
      r_frame    <= w_frame;
      r_clkOe    <= w_clkOe;
      r_dataOe   <= w_dataOe;
      r_busy     <= (w_nextState != IDLE);
      r_ready    <= (w_nextState == IDLE);
      r_done     <= (w_nextState == DONE);
      r_error    <= (w_nextState == ERR);
      r_clkMeta  <= i_ps2_clk_in;
      r_clkSync  <= r_clkMeta;
      r_clkPrev  <= r_clkSync;
      r_dataMeta <= i_ps2_data_in;
      r_dataSync <= r_dataMeta;
    end
  end

  assign o_tx_ready    = r_ready;
  assign o_busy        = r_busy;
  assign o_tx_done     = r_done;
  assign o_tx_error    = r_error;
  assign o_ps2_clk_oe  = r_clkOe;
  assign o_ps2_data_oe = r_dataOe;

endmodule
